unidade_controle_registradores: RTL and testbench

- Upstream/downstream partner of the 8:1 8-bit bus multiplexer.
- Holds the eight general registers R0..R7; their outputs drive the mux data inputs (r0 to entrada0 ... r7 to entrada7).
- Drives the mux select (controle) and takes the mux output back as write data (barramento).
- Executes one 9-bit instruction per iniciar request using a small multi-cycle FSM, forming the bus-based datapath.

---
 rtl/unidade_controle_registradores_if.sv | 33 +++
 rtl/unidade_controle_registradores.sv | 144 ++++++++++++++
 tb/tb_unidade_controle_registradores.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_registradores_if.sv
// Port bundle between the register/control unit and its environment
// (instruction source plus the external 8:1 bus multiplexer).
interface unidade_controle_registradores_if #(
    parameter int unsigned LARGURA = 8
);
    logic               iniciar;
    logic [8:0]         instrucao;
    logic [LARGURA-1:0] imediato;
    logic [LARGURA-1:0] barramento;
    logic [2:0]         controle;
    logic [LARGURA-1:0] r0;
    logic [LARGURA-1:0] r1;
    logic [LARGURA-1:0] r2;
    logic [LARGURA-1:0] r3;
    logic [LARGURA-1:0] r4;
    logic [LARGURA-1:0] r5;
    logic [LARGURA-1:0] r6;
    logic [LARGURA-1:0] r7;
    logic               ocupado;
    logic               pronto;

    // Environment side: issues instructions and closes the mux loop.
    modport master (
        output iniciar, instrucao, imediato, barramento,
        input  controle, r0, r1, r2, r3, r4, r5, r6, r7, ocupado, pronto
    );

    // Control unit side.
    modport slave (
        input  iniciar, instrucao, imediato, barramento,
        output controle, r0, r1, r2, r3, r4, r5, r6, r7, ocupado, pronto
    );
endinterface

// File: rtl/unidade_controle_registradores.sv
// Register file R0..R7 plus a multi-cycle FSM that executes mv/mvi/add/sub
// through an external 8:1 bus multiplexer (controle selects, barramento returns).
module unidade_controle_registradores #(
    parameter int unsigned LARGURA = 8
) (
    input logic                            clock,
    input logic                            reset,
    unidade_controle_registradores_if.slave bus
);
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IR_W     = 9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        T1     = 2'd1,
        T2     = 2'd2,
        T3     = 2'd3
    } estado_t;

    estado_t            state_q, state_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [LARGURA-1:0] imm_q, imm_d;
    logic [LARGURA-1:0] a_q, a_d;
    logic [LARGURA-1:0] g_q, g_d;
    logic [LARGURA-1:0] regs_q [NUM_REGS];
    logic [LARGURA-1:0] regs_d [NUM_REGS];
    logic               pronto_q, pronto_d;
    logic [2:0]         controle_c;

    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_arith;

    assign op       = ir_q[8:6];
    assign rx       = ir_q[5:3];
    assign ry       = ir_q[2:0];
    assign is_arith = (op == OP_ADD) || (op == OP_SUB);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= OCIOSO;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and completion-pulse registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            g_q      <= '0;
            pronto_q <= 1'b0;
            regs_q   <= '{default: '0};
        end else begin
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            g_q      <= g_d;
            pronto_q <= pronto_d;
            regs_q   <= regs_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO: if (bus.iniciar) state_d = T1;
            T1:     state_d = is_arith ? T2 : OCIOSO;
            T2:     state_d = T3;
            T3:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    // Mux select, register writes and completion pulse per state
    always_comb begin
        ir_d       = ir_q;
        imm_d      = imm_q;
        a_d        = a_q;
        g_d        = g_q;
        regs_d     = regs_q;
        pronto_d   = 1'b0;
        controle_c = 3'b000;
        case (state_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    ir_d  = bus.instrucao;
                    imm_d = bus.imediato;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        controle_c = ry;
                        regs_d[rx] = bus.barramento;
                        pronto_d   = 1'b1;
                    end
                    OP_MVI: begin
                        regs_d[rx] = imm_q;
                        pronto_d   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        controle_c = rx;
                        a_d        = bus.barramento;
                    end
                    default: pronto_d = 1'b1;
                endcase
            end
            T2: begin
                // Width-matched operands: carry/borrow fall off the top.
                controle_c = ry;
                g_d = (op == OP_SUB) ? LARGURA'(a_q - bus.barramento)
                                     : LARGURA'(a_q + bus.barramento);
            end
            T3: begin
                regs_d[rx] = g_q;
                pronto_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.controle = controle_c;
    assign bus.ocupado  = (state_q != OCIOSO);
    assign bus.pronto   = pronto_q;
    assign bus.r0       = regs_q[0];
    assign bus.r1       = regs_q[1];
    assign bus.r2       = regs_q[2];
    assign bus.r3       = regs_q[3];
    assign bus.r4       = regs_q[4];
    assign bus.r5       = regs_q[5];
    assign bus.r6       = regs_q[6];
    assign bus.r7       = regs_q[7];
endmodule

// File: tb/tb_unidade_controle_registradores.sv
// Directed bench: closes the bus loop with an 8:1 mux and checks each step.
module tb_unidade_controle_registradores;
    logic clock;
    logic reset;
    int   tests;
    int   failed;

    unidade_controle_registradores_if #(.LARGURA(8)) bus ();

    unidade_controle_registradores #(.LARGURA(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // External 8:1 bus multiplexer
    always_comb begin
        case (bus.controle)
            3'd0: bus.barramento = bus.r0;
            3'd1: bus.barramento = bus.r1;
            3'd2: bus.barramento = bus.r2;
            3'd3: bus.barramento = bus.r3;
            3'd4: bus.barramento = bus.r4;
            3'd5: bus.barramento = bus.r5;
            3'd6: bus.barramento = bus.r6;
            3'd7: bus.barramento = bus.r7;
            default: bus.barramento = 8'h00;
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        return {op, x, y};
    endfunction

    // Start an instruction and advance n edges (1st edge samples iniciar)
    task automatic run(input logic [8:0] instr, input logic [7:0] imm, input int n);
        bus.iniciar   = 1'b1;
        bus.instrucao = instr;
        bus.imediato  = imm;
        step();
        bus.iniciar = 1'b0;
        for (int i = 1; i < n; i++) step();
    endtask

    initial begin
        tests         = 0;
        failed        = 0;
        reset         = 1'b0;
        bus.iniciar   = 1'b0;
        bus.instrucao = 9'd0;
        bus.imediato  = 8'h00;

        // Asynchronous reset mid-cycle
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("reset_regs", {bus.r0, bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7}, 64'h0);
        chk("reset_controle", 64'(bus.controle), 64'h0);
        chk("reset_ocupado", 64'(bus.ocupado), 64'h0);
        chk("reset_pronto", 64'(bus.pronto), 64'h0);
        step();
        reset = 1'b0;
        step();

        // mvi R2,#5A
        run(ins(3'b001, 3'd2, 3'd0), 8'h5A, 1);
        chk("mvi_t1_controle", 64'(bus.controle), 64'h0);
        chk("mvi_t1_ocupado", 64'(bus.ocupado), 64'h1);
        chk("mvi_t1_pronto", 64'(bus.pronto), 64'h0);
        step();
        chk("mvi_r2", 64'(bus.r2), 64'h5A);
        chk("mvi_pronto", 64'(bus.pronto), 64'h1);
        chk("mvi_others", {bus.r0, bus.r1, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7}, 64'h0);
        step();
        chk("mvi_pronto_drop", 64'(bus.pronto), 64'h0);

        // mv R7,R2 through the mux
        run(ins(3'b000, 3'd7, 3'd2), 8'h00, 1);
        chk("mv_controle", 64'(bus.controle), 64'h2);
        step();
        chk("mv_r7", 64'(bus.r7), 64'h5A);
        chk("mv_pronto", 64'(bus.pronto), 64'h1);

        // mv R0,R0 (back-to-back after pronto)
        run(ins(3'b000, 3'd0, 3'd0), 8'h00, 2);
        chk("mv_r0_r0", 64'(bus.r0), 64'h0);
        chk("mv_r0_pronto", 64'(bus.pronto), 64'h1);

        // add R1,R2 with R1=F0, R2=25
        run(ins(3'b001, 3'd1, 3'd0), 8'hF0, 2);
        run(ins(3'b001, 3'd2, 3'd0), 8'h25, 2);
        run(ins(3'b010, 3'd1, 3'd2), 8'h00, 1);
        chk("add_t1_controle", 64'(bus.controle), 64'h1);
        step();
        chk("add_t2_controle", 64'(bus.controle), 64'h2);
        step();
        chk("add_t3_controle", 64'(bus.controle), 64'h0);
        chk("add_t3_pronto", 64'(bus.pronto), 64'h0);
        chk("add_t3_r1_old", 64'(bus.r1), 64'hF0);
        step();
        chk("add_r1_wrap", 64'(bus.r1), 64'h15);
        chk("add_pronto", 64'(bus.pronto), 64'h1);
        step();
        chk("add_pronto_drop", 64'(bus.pronto), 64'h0);

        // sub underflow and aliasing
        run(ins(3'b001, 3'd5, 3'd0), 8'h01, 2);
        run(ins(3'b011, 3'd4, 3'd5), 8'h00, 4);
        chk("sub_underflow", 64'(bus.r4), 64'hFF);
        run(ins(3'b010, 3'd4, 3'd4), 8'h00, 4);
        chk("add_alias", 64'(bus.r4), 64'hFE);
        run(ins(3'b011, 3'd4, 3'd4), 8'h00, 4);
        chk("sub_alias", 64'(bus.r4), 64'h00);
        step();

        // iniciar held high, instrucao changing while busy
        bus.iniciar   = 1'b1;
        bus.instrucao = ins(3'b010, 3'd1, 3'd2);
        bus.imediato  = 8'h00;
        step();
        bus.instrucao = ins(3'b001, 3'd6, 3'd0);
        bus.imediato  = 8'hAA;
        step();
        bus.imediato  = 8'hBB;
        step();
        bus.imediato  = 8'hCC;
        step();
        chk("hold_r1", 64'(bus.r1), 64'h3A);
        chk("hold_pronto", 64'(bus.pronto), 64'h1);
        chk("hold_r6_untouched", 64'(bus.r6), 64'h00);
        step();
        bus.iniciar = 1'b0;
        chk("hold_accept_busy", 64'(bus.ocupado), 64'h1);
        step();
        chk("hold_r6", 64'(bus.r6), 64'hCC);

        // Back-to-back mvi R3
        run(ins(3'b001, 3'd3, 3'd0), 8'h11, 2);
        chk("b2b_first", 64'(bus.r3), 64'h11);
        chk("b2b_first_pronto", 64'(bus.pronto), 64'h1);
        run(ins(3'b001, 3'd3, 3'd0), 8'h22, 1);
        chk("b2b_gap_pronto", 64'(bus.pronto), 64'h0);
        step();
        chk("b2b_second", 64'(bus.r3), 64'h22);
        chk("b2b_second_pronto", 64'(bus.pronto), 64'h1);

        // nop (opcode 101)
        run(ins(3'b101, 3'd3, 3'd0), 8'h99, 2);
        chk("nop_pronto", 64'(bus.pronto), 64'h1);
        chk("nop_regs", {bus.r0, bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7},
            64'h00_3A_25_22_00_01_CC_5A);
        step();

        // Reset during T2 of add R1,R2
        run(ins(3'b010, 3'd1, 3'd2), 8'h00, 2);
        chk("abort_in_t2", 64'(bus.controle), 64'h2);
        #2 reset = 1'b1;
        #1;
        chk("abort_r1", 64'(bus.r1), 64'h00);
        chk("abort_ocupado", 64'(bus.ocupado), 64'h0);
        step();
        reset = 1'b0;
        step();
        chk("abort_no_pronto", 64'(bus.pronto), 64'h0);
        chk("abort_regs", {bus.r0, bus.r1, bus.r2, bus.r3, bus.r4, bus.r5, bus.r6, bus.r7}, 64'h0);

        // Fresh mvi after reset
        run(ins(3'b001, 3'd1, 3'd0), 8'h77, 2);
        chk("post_reset_mvi", 64'(bus.r1), 64'h77);
        chk("post_reset_pronto", 64'(bus.pronto), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
